mod_div_fast: RTL and testbench
===============================

MOD_DIV_FAST -- requirements
Module: mod_div_fast

Interface
REQ-001 Parameter WIDTH, default 16, sets the operand, divisor, remainder and quotient width in bits.
REQ-002 Parameter K, default 5, sets the maximum number of divisor multiples removed per OP cycle; legal range 1..15.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 start  input  1  request a new operation; sampled only while ready=1.
REQ-006 n  input  WIDTH  dividend, unsigned; sampled on the accepted start.
REQ-007 d  input  WIDTH  divisor, unsigned; sampled on the accepted start.
REQ-008 ready  output  1  high while in IDLE; start is accepted.
REQ-009 done  output  1  one-cycle pulse; result is valid.
REQ-010 remain  output  WIDTH  n mod d.
REQ-011 quot  output  WIDTH  floor(n / d).
REQ-012 err  output  1  divide-by-zero flag for the current result.

Function
REQ-013 FSM states: IDLE, OP, DONE; ready = (state==IDLE); done = (state==DONE); both decode from registered state only.
REQ-014 IDLE with start=1: latch temp=n and div=d, clear quot and err; next state is OP if d!=0, else DONE.
REQ-015 IDLE with start=0: remain in IDLE with temp, quot and err held.
REQ-016 OP each cycle: j = largest m in 0..K with m*div <= temp; temp <= temp - j*div; quot <= quot + j.
REQ-017 OP exit: if j<K, next state is DONE; if j==K, stay in OP.
REQ-018 Products m*div are computed at WIDTH+4 bits; no comparison may be truncated or wrap.
REQ-019 Quotient accumulation is at WIDTH bits; it cannot overflow because quot <= n.
REQ-020 OP cycle count = floor(floor(n/d)/K)+1; done is asserted OP-count+1 cycles after the start edge.
REQ-021 d==0: skip OP, enter DONE the cycle after start, with remain=n, quot=all ones, err=1.
REQ-022 DONE lasts exactly one cycle, then the state returns to IDLE unconditionally.
REQ-023 remain = temp and quot are registered; they hold the last result from DONE until the next accepted start clears quot.
REQ-024 start while in OP or DONE is ignored; n and d changes after acceptance have no effect.
REQ-025 Back-to-back operation: start may be accepted in the first IDLE cycle after DONE; minimum spacing between accepted starts is OP-count+2 cycles.

Reset
REQ-026 rst=1 at any clock edge, including mid-OP: state=IDLE, temp=0, quot=0, err=0, div=0.
REQ-027 Output values while in reset and in the cycle after it: ready=1, done=0, remain=0, quot=0, err=0.
REQ-028 An operation interrupted by reset produces no done pulse; start sampled in the reset cycle is discarded.

Verification (WIDTH=16, K=5)
REQ-029 n=1234, d=100, single start -> OP for 3 cycles; done in cycle 4 after start; remain=34, quot=12, err=0.
REQ-030 n=50, d=100 -> 1 OP cycle; done in cycle 2; remain=50, quot=0. Also n=1000, d=100 -> 3 OP cycles; remain=0, quot=10.
REQ-031 n=65535, d=1 -> 13108 OP cycles; remain=0, quot=65535; no overflow. Also n=65535, d=65535 -> remain=0, quot=1.
REQ-032 d=0, n=777 -> done in cycle 2; err=1, remain=777, quot=16'hFFFF; the next op with d=7 clears err.
REQ-033 rst pulsed during the 2nd OP cycle of n=1234, d=100 -> no done pulse; ready=1 and outputs 0 next cycle; a new op then completes correctly.
REQ-034 start held high continuously with changing n/d -> only the IDLE-cycle samples are used; each result matches the reference model for its accepted operands.

Source files
------------

// File: rtl/mod_div_fast_if.sv
// mod_div_fast_if: start/operand/result bundle for the multi-step divider
interface mod_div_fast_if #(parameter int WIDTH = 16);
    logic             start;
    logic [WIDTH-1:0] n;
    logic [WIDTH-1:0] d;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] remain;
    logic [WIDTH-1:0] quot;
    logic             err;
    modport master (output start, n, d, input ready, done, remain, quot, err);
    modport slave  (input start, n, d, output ready, done, remain, quot, err);
endinterface

// File: rtl/mod_div_fast.sv
// mod_div_fast: divider removing up to K divisor multiples per cycle
module mod_div_fast #(
    parameter int WIDTH = 16,
    parameter int K     = 5
) (
    input logic          clk,
    input logic          rst,
    mod_div_fast_if.slave bus
);
    localparam int PW = WIDTH + 4;
    localparam logic [3:0] KL = 4'(K);
    typedef enum logic [1:0] {IDLE, OP, DONE} state_t;
    state_t           state, nxt;
    logic [WIDTH-1:0] temp, div, quot;
    logic             err;
    logic [3:0]       j;
    logic [WIDTH-1:0] jdiv;
    // Pick the largest multiple count that still fits; products are kept wide so nothing wraps
    always_comb begin
        j = '0;
        for (int m = 1; m <= K; m++)
            if (PW'(m) * {4'b0, div} <= {4'b0, temp}) j = 4'(m);
        jdiv = WIDTH'({{(PW-4){1'b0}}, j} * {4'b0, div});
    end
    // Next-state: a short step (j<K) means the remainder is below div and we are finished
    always_comb begin
        nxt = state;
        if (state == IDLE && bus.start) nxt = (bus.d != '0) ? OP : DONE;
        else if (state == OP && j < KL) nxt = DONE;
        else if (state == DONE) nxt = IDLE;
    end
    // State and datapath registers; divide-by-zero preloads the error result directly
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            temp  <= '0;
            div   <= '0;
            quot  <= '0;
            err   <= 1'b0;
        end else begin
            state <= nxt;
            if (state == IDLE && bus.start) begin
                temp <= bus.n;
                div  <= bus.d;
                quot <= (bus.d == '0) ? '1 : '0;
                err  <= (bus.d == '0);
            end else if (state == OP) begin
                temp <= temp - jdiv;
                quot <= quot + WIDTH'(j);
            end
        end
    end
    assign bus.ready  = (state == IDLE);
    assign bus.done   = (state == DONE);
    assign bus.remain = temp;
    assign bus.quot   = quot;
    assign bus.err    = err;
endmodule

// File: tb/tb_mod_div_fast.sv
// tb_mod_div_fast: vector table, corner sequences and random ops against an arithmetic model
module tb_mod_div_fast;
    localparam int K = 5;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    always #5 clk = ~clk;
    mod_div_fast_if #(.WIDTH(16)) bus ();
    mod_div_fast #(.WIDTH(16), .K(K)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [15:0] n, d, r, q;
        logic        e;
        int          lat;
    } vec_t;

    vec_t tbl [10];
    vec_t pend [$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic vec_t model(input logic [15:0] n, input logic [15:0] d);
        vec_t v;
        v.n   = n;
        v.d   = d;
        v.e   = (d == 0);
        v.q   = v.e ? 16'hFFFF : 16'(int'(n) / int'(d));
        v.r   = v.e ? n : 16'(int'(n) % int'(d));
        v.lat = v.e ? 1 : int'(v.q) / K + 2;
        return v;
    endfunction

    task automatic run_op(input vec_t v);
        int lat;
        @(negedge clk);
        chk("ready_before", 32'(bus.ready), 1);
        bus.start = 1'b1;
        bus.n = v.n;
        bus.d = v.d;
        @(negedge clk);
        lat = 1;
        while (!bus.done && lat < 20000) begin
            bus.start = 1'($urandom_range(0, 1));
            bus.n = 16'($urandom);
            bus.d = 16'($urandom);
            @(negedge clk);
            lat++;
        end
        bus.start = 1'b0;
        chk("latency", 32'(lat), 32'(v.lat));
        chk("remain", 32'(bus.remain), 32'(v.r));
        chk("quot", 32'(bus.quot), 32'(v.q));
        chk("err", 32'(bus.err), 32'(v.e));
        @(negedge clk);
        chk("done_pulse", 32'(bus.done), 0);
        chk("ready_after", 32'(bus.ready), 1);
        chk("remain_hold", 32'(bus.remain), 32'(v.r));
        chk("quot_hold", 32'(bus.quot), 32'(v.q));
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_ready"}, 32'(bus.ready), 1);
        chk({tag, "_done"}, 32'(bus.done), 0);
        chk({tag, "_remain"}, 32'(bus.remain), 0);
        chk({tag, "_quot"}, 32'(bus.quot), 0);
        chk({tag, "_err"}, 32'(bus.err), 0);
    endtask

    initial begin
        int seen_done;
        int held_ops;
        vec_t v;
        tbl[0] = '{16'd1234,  16'd100,   16'd34,  16'd12,    1'b0, 4};
        tbl[1] = '{16'd50,    16'd100,   16'd50,  16'd0,     1'b0, 2};
        tbl[2] = '{16'd1000,  16'd100,   16'd0,   16'd10,    1'b0, 4};
        tbl[3] = '{16'd65535, 16'd65535, 16'd0,   16'd1,     1'b0, 2};
        tbl[4] = '{16'd777,   16'd0,     16'd777, 16'hFFFF,  1'b1, 1};
        tbl[5] = '{16'd100,   16'd7,     16'd2,   16'd14,    1'b0, 4};
        tbl[6] = '{16'd0,     16'd5,     16'd0,   16'd0,     1'b0, 2};
        tbl[7] = '{16'd25,    16'd5,     16'd0,   16'd5,     1'b0, 3};
        tbl[8] = '{16'd24,    16'd5,     16'd4,   16'd4,     1'b0, 2};
        tbl[9] = '{16'd65535, 16'd1,     16'd0,   16'd65535, 1'b0, 13109};
        rst = 1'b1;
        bus.start = 1'b1;
        bus.n = 16'd9;
        bus.d = 16'd3;
        repeat (2) @(negedge clk);
        chk_idle_zero("in_reset");
        rst = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        chk_idle_zero("after_reset");
        foreach (tbl[i]) run_op(tbl[i]);
        // reset in the second OP cycle of 1234/100
        seen_done = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.n = 16'd1234;
        bus.d = 16'd100;
        @(negedge clk);
        bus.start = 1'b0;
        seen_done += int'(bus.done);
        @(negedge clk);
        seen_done += int'(bus.done);
        rst = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.start = 1'b0;
        chk_idle_zero("mid_op_reset");
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            seen_done += int'(bus.done);
        end
        chk("reset_no_done", 32'(seen_done), 0);
        chk("reset_start_discarded", 32'(bus.ready), 1);
        run_op(tbl[0]);
        // random ops against the model
        for (int i = 0; i < 40; i++) begin
            logic [15:0] rn, rd;
            rn = 16'($urandom);
            rd = (i % 4 == 0) ? 16'($urandom_range(0, 300)) : 16'($urandom_range(1, 65535));
            if (i % 4 == 0 && rd != 0) rn = 16'($urandom_range(0, 300 * int'(rd)));
            run_op(model(rn, rd));
        end
        // start held high with operands changing every cycle
        held_ops = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (bus.done) begin
                if (pend.size() == 0) chk("held_spurious_done", 1, 0);
                else begin
                    v = pend.pop_front();
                    chk("held_remain", 32'(bus.remain), 32'(v.r));
                    chk("held_quot", 32'(bus.quot), 32'(v.q));
                    chk("held_err", 32'(bus.err), 32'(v.e));
                    held_ops++;
                end
            end
            bus.n = 16'($urandom);
            bus.d = 16'($urandom_range(0, 300));
            if (bus.d != 0 && int'(bus.n) / int'(bus.d) > 200) bus.n = 16'(int'(bus.n) % (int'(bus.d) * 50 + 1));
            bus.start = (c < 590);
            if (bus.ready && c < 590) pend.push_back(model(bus.n, bus.d));
        end
        for (int c = 0; c < 2000 && pend.size() > 0; c++) begin
            @(negedge clk);
            if (bus.done) begin
                v = pend.pop_front();
                chk("held_remain", 32'(bus.remain), 32'(v.r));
                chk("held_quot", 32'(bus.quot), 32'(v.q));
                chk("held_err", 32'(bus.err), 32'(v.e));
                held_ops++;
            end
        end
        chk("held_drained", 32'(pend.size()), 0);
        chk("held_enough_ops", 32'(held_ops >= 5), 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
